// File: rtl/hex_scan_mux.sv
// Time-multiplexed scan driver for a 4-digit common-anode 7-segment display.
// Optional leading-zero blanking is compiled in when HEX_SCAN_LZB_EN is defined.
module hex_scan_mux #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic [3:0]  hex_out,
    output logic        dp_out,
    output logic [3:0]  digit_en_n,
    output logic [1:0]  digit_idx,
    output logic        frame_tick
);

    localparam int            CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] TC = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] r_presc;
    logic [1:0]    r_slot;
    logic [15:0]   r_pend_val;
    logic [3:0]    r_pend_dp;
    logic          r_pend_flag;
    logic [15:0]   r_disp_val;
    logic [3:0]    r_disp_dp;

    logic [3:0]    r_hex;
    logic          r_dp;
    logic [3:0]    r_en_n;
    logic [1:0]    r_idx;
    logic          r_tick;

    logic          w_tc;
    logic          w_blank;
    logic [3:0]    w_lzb_mask;
    logic [3:0]    w_en_n;

    assign w_tc = (r_presc == TC);

    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign w_blank = 1'b0;
        end else begin : g_blank
            assign w_blank = (r_presc < CW'(BLANK_CYCLES));
        end
    endgenerate

`ifdef HEX_SCAN_LZB_EN
    // A digit is suppressed only if it and every digit to its left is a bare zero.
    always_comb begin
        w_lzb_mask    = 4'b0000;
        w_lzb_mask[3] = (r_disp_val[15:12] == 4'h0) && !r_disp_dp[3];
        w_lzb_mask[2] = w_lzb_mask[3] && (r_disp_val[11:8] == 4'h0) && !r_disp_dp[2];
        w_lzb_mask[1] = w_lzb_mask[2] && (r_disp_val[7:4] == 4'h0) && !r_disp_dp[1];
    end
    assign w_en_n = w_blank ? 4'b1111 : (~(4'b0001 << r_slot) | w_lzb_mask);
`else
    assign w_lzb_mask = 4'b0000;
    assign w_en_n     = w_blank ? 4'b1111 : ~(4'b0001 << r_slot);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_slot  <= 2'd0;
        end else if (w_tc) begin
            r_presc <= '0;
            r_slot  <= r_slot + 2'd1;
        end else begin
            r_presc <= r_presc + CW'(1);
        end
    end

    // A load coincident with a slot boundary goes straight to the display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_val  <= 16'h0000;
            r_pend_dp   <= 4'h0;
            r_pend_flag <= 1'b0;
            r_disp_val  <= 16'h0000;
            r_disp_dp   <= 4'h0;
        end else begin
            if (load) begin
                r_pend_val <= value_in;
                r_pend_dp  <= dp_in;
            end
            if (w_tc) begin
                r_pend_flag <= 1'b0;
                if (load) begin
                    r_disp_val <= value_in;
                    r_disp_dp  <= dp_in;
                end else if (r_pend_flag) begin
                    r_disp_val <= r_pend_val;
                    r_disp_dp  <= r_pend_dp;
                end
            end else if (load) begin
                r_pend_flag <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hex  <= 4'h0;
            r_dp   <= 1'b0;
            r_en_n <= 4'b1111;
            r_idx  <= 2'd0;
            r_tick <= 1'b0;
        end else begin
            r_hex  <= r_disp_val[{r_slot, 2'b00} +: 4];
            r_dp   <= r_disp_dp[r_slot];
            r_en_n <= w_en_n;
            r_idx  <= r_slot;
            r_tick <= (r_presc == '0) && (r_slot == 2'd0);
        end
    end

    assign hex_out    = r_hex;
    assign dp_out     = r_dp;
    assign digit_en_n = r_en_n;
    assign digit_idx  = r_idx;
    assign frame_tick = r_tick;

endmodule

// File: tb/tb_hex_scan_mux.sv
// Scoreboard bench for hex_scan_mux: per-cycle expectations are queued from
// hand-written per-slot display tables and popped by a free-running monitor.
module tb_hex_scan_mux;

    localparam int RD = 8;
    localparam int BL = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic        load;
    logic [3:0]  hex_out;
    logic        dp_out;
    logic [3:0]  digit_en_n;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    typedef struct packed {
        logic [3:0] hex;
        logic       dp;
        logic [3:0] en;
        logic [1:0] idx;
        logic       tick;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] tv[16];
    logic [3:0]  td[16];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          mon_cyc  = 0;
    int          m        = 0;
    logic        mon_on   = 1'b0;

    hex_scan_mux #(.REFRESH_DIV(RD), .BLANK_CYCLES(BL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value_in   (value_in),
        .dp_in      (dp_in),
        .load       (load),
        .hex_out    (hex_out),
        .dp_out     (dp_out),
        .digit_en_n (digit_en_n),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] exp_en(input int p, input int idx,
                                          input logic [15:0] v, input logic [3:0] d);
        logic [3:0] e;
        if (p < BL) return 4'b1111;
        e = ~(4'b0001 << idx);
`ifdef HEX_SCAN_LZB_EN
        if (idx > 0 && (v >> (4 * idx)) == 16'h0 && (d >> idx) == 4'h0) e = 4'b1111;
`endif
        return e;
    endfunction

    task automatic push_slots(input int nslots);
        exp_t e;
        int   idx;
        for (int s = 0; s < nslots; s++) begin
            idx = s % 4;
            for (int p = 0; p < RD; p++) begin
                e.hex  = tv[s][4*idx +: 4];
                e.dp   = td[s][idx];
                e.en   = exp_en(p, idx, tv[s], td[s]);
                e.idx  = idx[1:0];
                e.tick = (p == 0) && (idx == 0);
                exp_q.push_back(e);
            end
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        exp_t g;
        #1;
        if (mon_on && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = '{hex: hex_out, dp: dp_out, en: digit_en_n, idx: digit_idx, tick: frame_tick};
            n_checks++;
            if (g === e) n_pass++;
            else $display("FAIL scan cycle %0d: got hex=%h dp=%b en=%b idx=%0d tick=%b, want hex=%h dp=%b en=%b idx=%0d tick=%b",
                          mon_cyc, g.hex, g.dp, g.en, g.idx, g.tick, e.hex, e.dp, e.en, e.idx, e.tick);
            mon_cyc++;
        end
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h", name, got, want);
    endtask

    task automatic goto(input int target);
        while (m < target) begin
            @(negedge clk);
            m++;
        end
    endtask

    task automatic do_load(input int t, input logic [15:0] v, input logic [3:0] d);
        goto(t);
        load     = 1'b1;
        value_in = v;
        dp_in    = d;
        @(negedge clk);
        m++;
        load = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en"},   16'(digit_en_n), 16'h000F);
        check({tag, "_hex"},  16'(hex_out),    16'h0000);
        check({tag, "_idx"},  16'(digit_idx),  16'h0000);
        check({tag, "_dp"},   16'(dp_out),     16'h0000);
        check({tag, "_tick"}, 16'(frame_tick), 16'h0000);
    endtask

    initial begin
        rst_n    = 1'b0;
        load     = 1'b0;
        value_in = 16'h0000;
        dp_in    = 4'h0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // Phase 1: scan order, deferred, coincident and double loads.
        tv[0] = 16'h0000; td[0] = 4'b0000;
        for (int s = 1; s <= 5; s++) begin tv[s] = 16'h12AF; td[s] = 4'b0100; end
        for (int s = 6; s <= 8; s++) begin tv[s] = 16'h0000; td[s] = 4'b0000; end
        tv[9]  = 16'h5555; td[9]  = 4'b0000;
        tv[10] = 16'h2222; td[10] = 4'b0000;
        tv[11] = 16'h2222; td[11] = 4'b0000;
        push_slots(12);

        rst_n  = 1'b1;
        m      = 0;
        mon_on = 1'b1;
        do_load(2,  16'h12AF, 4'b0100);
        do_load(43, 16'h0000, 4'b0000);
        do_load(71, 16'h5555, 4'b0000);
        check("pend_flag_after_coincident", 16'(dut.r_pend_flag), 16'h0000);
        do_load(74, 16'h1111, 4'b0000);
        do_load(76, 16'h2222, 4'b0000);
        goto(96);
        check("phase1_drain", 16'(exp_q.size()), 16'h0000);
        mon_on = 1'b0;

        // Mid-scan asynchronous reset while digit 0 is lit with 2.
        goto(100);
        check("pre_reset_en",  16'(digit_en_n), 16'h000E);
        check("pre_reset_hex", 16'(hex_out),    16'h0002);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");

        // Phase 2: restart from zero, then leading-zero patterns.
        tv[0] = 16'h0000; td[0] = 4'b0000;
        for (int s = 1; s <= 3; s++) begin tv[s] = 16'h0007; td[s] = 4'b0000; end
        for (int s = 4; s <= 7; s++) begin tv[s] = 16'h0007; td[s] = 4'b0100; end
        push_slots(8);

        @(negedge clk);
        rst_n  = 1'b1;
        m      = 0;
        mon_on = 1'b1;
        do_load(2,  16'h0007, 4'b0000);
        do_load(26, 16'h0007, 4'b0100);
        goto(64);
        check("phase2_drain", 16'(exp_q.size()), 16'h0000);
        mon_on = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
